simple_spi_master: RTL and testbench
====================================

# simple_spi_master

SPI master that exchanges one word of fixed `WIDTH` per transaction with a single slave: MSB first, CPOL=0, CPHA=0, active-low chip select. The block is the initiator counterpart to our `simple_spi_slave` and generates SCLK, nCS and MOSI from `system_clk` via a programmable half-period divider. It sits between a local controller (start/done handshake) and the board pins.

## Interface
- `WIDTH`, 32: bits per transaction; must be ≥2.
- `CLK_HALF`, 8: system clocks per SPI half-period. It also sets the nCS setup time, the nCS hold time and the inter-transfer gap. Minimum is 2; use ≥8 when talking to `simple_spi_slave`, because of its 4-stage input stabilizers.

Ports (synchronous, active-high reset):
- `system_clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; accepted only in IDLE.
- `value_mosi`  in  WIDTH  word to send; captured on the accept cycle.
- `value_miso`  out  WIDTH  word received; updated only on `done`.
- `busy`  out  1  high from the cycle after accept until the end of GAP.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `pin_ncs`  out  1  chip select, active low.
- `pin_clk`  out  1  SPI clock, idle low.
- `pin_mosi`  out  1  serial data out.
- `pin_miso`  in  1  serial data in; asynchronous, passed through a 2-flop synchronizer.

## Operation
- FSM states are IDLE, SETUP, HIGH, LOW, HOLD and GAP.
- A half-period counter reloads to `CLK_HALF`-1 on each state entry. Every non-IDLE state lasts exactly `CLK_HALF` cycles.
- A bit counter of width `$clog2(WIDTH+1)` counts completed HIGH phases.
- **IDLE:** ncs=1, clk=0, mosi=0, busy=0. If `start` is high, load the shift register with `value_mosi`, clear the bit counter, and go to SETUP.
- **SETUP:** ncs=0, clk=0, mosi=shift[WIDTH-1]. Then go to HIGH.
- **HIGH:** clk=1.
  - On the last cycle of HIGH, shift the synchronized MISO into the receive register (MSB first) and increment the bit counter.
  - If the counter reaches WIDTH, go to HOLD; otherwise go to LOW.
- **LOW:** clk=0. On entry, shift the transmit register left by one so that mosi presents the next bit on the falling edge. Then go to HIGH.
- **HOLD:** ncs=0, clk=0, mosi holds the last bit. Then go to GAP.
- **GAP:**
  - ncs=1, clk=0, mosi=0.
  - On the entry cycle, `value_miso` is loaded from the receive register and `done`=1 for one cycle.
  - Then go to IDLE.
- `start` while busy is ignored; it is not queued.
- `value_mosi` changes after the accept cycle have no effect.
- Receive register and `value_miso` are exactly WIDTH bits; no wrap or overflow is possible.

## Timing
- Reset values: ncs=1, clk=0, mosi=0, busy=0, done=0, value_miso=0, FSM=IDLE, synchronizer=0.
- With `start` accepted in cycle 0 and H=`CLK_HALF`:
  - nCS falls in cycle 1.
  - The first rising SCLK edge is in cycle H+1.
  - There are WIDTH high phases and WIDTH-1 low phases.
  - nCS rises and `done` pulses in cycle (2·WIDTH+1)·H+1.
  - `busy` drops in cycle (2·WIDTH+2)·H+1, which is the earliest cycle a new `start` is accepted.
- MOSI is stable ≥H cycles before every rising edge and ≥H cycles after it.
- MISO is taken from the synchronizer output on the last HIGH cycle. It therefore reflects the pin 2 cycles earlier, i.e. within the high phase.
- `reset` mid-transfer: the next cycle is IDLE with ncs=1 and clk=0. No `done` pulse; `value_miso` returns to 0.
- `start` asserted in the same cycle as `reset`: ignored.

## Test plan
- **Reset:** hold `reset` for 3 cycles -> ncs=1, clk=0, mosi=0, busy=0, done=0, value_miso=0.
- **Loopback** (WIDTH=8, H=4, pin_miso tied to pin_mosi), `start` with `value_mosi`=0xA5:
  - nCS falls at cycle 1.
  - Exactly 8 rising edges are observed.
  - MOSI sequence is 1,0,1,0,0,1,0,1.
  - `done` at cycle 69 with `value_miso`=0xA5.
  - `busy` falls at cycle 73.
- **Slave pairing:** WIDTH=32, H=8, connected to `simple_spi_slave`. Master sends 0xDEADBEEF and the slave returns 0x12345678 -> slave `value_mosi`=0xDEADBEEF with `value_valid` pulsed; master `value_miso`=0x12345678.
- **Busy rejection:** pulse `start` with 0xFF at cycle 10 of a 0x00 transfer -> MOSI stays 0 throughout, only one `done`, and no second transaction starts.
- **Back-to-back:** `start` held high continuously with `value_mosi`=0x3C then 0xC3 -> second nCS fall occurs exactly 1 cycle after `busy` drops, and the two transactions are separated by ≥H cycles with ncs=1.
- **Abort:** assert `reset` at cycle 30 of a WIDTH=8, H=4 transfer -> ncs=1 the next cycle, no `done`, `value_miso`=0; a new `start` then completes normally.

Source files
------------

// File: rtl/simple_spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one WIDTH-bit word per
// transaction. SCLK, nCS and MOSI are derived from system_clk through a
// half-period counter. All pin and handshake outputs are registered from the
// next-state decode, so they change in the same cycle the FSM enters a state.
module simple_spi_master #(
    parameter int WIDTH    = 32,
    parameter int CLK_HALF = 8
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_HALF - 1);
    localparam logic [CW-1:0] BIT_LAST    = CW'(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t           state_r, state_next_s;
    logic [HW-1:0]    half_cnt_r, half_cnt_next_s;
    logic [CW-1:0]    bit_cnt_r, bit_cnt_next_s;
    logic [WIDTH-1:0] tx_r, tx_next_s;
    logic [WIDTH-1:0] rx_r, rx_next_s;
    logic [WIDTH-1:0] value_miso_next_s;
    logic             miso_meta_r, miso_sync_r;
    logic             phase_end_s, active_s;
    logic             done_next_s;

    // Next-state, datapath updates and next output values
    always_comb begin
        state_next_s      = state_r;
        tx_next_s         = tx_r;
        rx_next_s         = rx_r;
        bit_cnt_next_s    = bit_cnt_r;
        value_miso_next_s = value_miso;
        done_next_s       = 1'b0;
        phase_end_s       = (half_cnt_r == '0);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    tx_next_s      = value_mosi;
                    bit_cnt_next_s = '0;
                    state_next_s   = ST_SETUP;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_end_s) begin
                    state_next_s = ST_HIGH;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (phase_end_s) begin
                    rx_next_s      = {rx_r[WIDTH-2:0], miso_sync_r};
                    bit_cnt_next_s = bit_cnt_r + CW'(1);
                    if (bit_cnt_next_s == BIT_LAST) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        // Shift on LOW entry so MOSI moves on the falling edge
                        tx_next_s    = {tx_r[WIDTH-2:0], 1'b0};
                        state_next_s = ST_LOW;
                    end
                end else begin
                    state_next_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (phase_end_s) begin
                    state_next_s = ST_HIGH;
                end else begin
                    state_next_s = ST_LOW;
                end
            end
            ST_HOLD: begin
                if (phase_end_s) begin
                    value_miso_next_s = rx_r;
                    done_next_s       = 1'b1;
                    state_next_s      = ST_GAP;
                end else begin
                    state_next_s      = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (phase_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Every state entry (and all of IDLE) restarts the half-period count
        if ((state_r == ST_IDLE) || phase_end_s) begin
            half_cnt_next_s = HALF_RELOAD;
        end else begin
            half_cnt_next_s = half_cnt_r - HW'(1);
        end

        active_s = (state_next_s == ST_SETUP) || (state_next_s == ST_HIGH) ||
                   (state_next_s == ST_LOW)   || (state_next_s == ST_HOLD);
    end

    // State, counters, shift registers and registered outputs
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            half_cnt_r  <= HALF_RELOAD;
            bit_cnt_r   <= '0;
            tx_r        <= '0;
            rx_r        <= '0;
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
            value_miso  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pin_ncs     <= 1'b1;
            pin_clk     <= 1'b0;
            pin_mosi    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            half_cnt_r  <= half_cnt_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            tx_r        <= tx_next_s;
            rx_r        <= rx_next_s;
            miso_meta_r <= pin_miso;
            miso_sync_r <= miso_meta_r;
            value_miso  <= value_miso_next_s;
            busy        <= (state_next_s != ST_IDLE);
            done        <= done_next_s;
            pin_ncs     <= ~active_s;
            pin_clk     <= (state_next_s == ST_HIGH);
            pin_mosi    <= active_s ? tx_next_s[WIDTH-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_simple_spi_master.sv
// Self-checking bench for simple_spi_master (WIDTH=8, CLK_HALF=4).
// Expected timing comes from the closed-form cycle formulas; expected data
// comes from the transmitted word (loopback) or a bench-driven MISO word.
module tb_simple_spi_master;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int T_DONE = (2 * W + 1) * H + 1;
    localparam int T_FREE = (2 * W + 2) * H + 1;

    logic         system_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] value_mosi;
    logic [W-1:0] value_miso;
    logic         busy, done, pin_ncs, pin_clk, pin_mosi, pin_miso;
    logic         loop_mode, miso_drv;

    int checks = 0;
    int errors = 0;

    assign pin_miso = loop_mode ? pin_mosi : miso_drv;

    simple_spi_master #(.WIDTH(W), .CLK_HALF(H)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .start      (start),
        .value_mosi (value_mosi),
        .value_miso (value_miso),
        .busy       (busy),
        .done       (done),
        .pin_ncs    (pin_ncs),
        .pin_clk    (pin_clk),
        .pin_mosi   (pin_mosi),
        .pin_miso   (pin_miso)
    );

    // Free-running system clock
    always #5 system_clk = ~system_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs n cycles expecting a quiet, deselected bus and no handshake activity
    task automatic idle_cycles(input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge system_clk);
            if (pin_ncs !== 1'b1 || pin_clk !== 1'b0 || pin_mosi !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    // Called at a negedge: start is raised in this cycle (cycle 0) and the
    // whole transaction is observed up to the cycle busy should drop.
    task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] rx, input bit lb,
                            input int reject_at, input bit hold, input logic [W-1:0] next_tx);
        int rises = 0, first_rise = -1, done_cnt = 0, done_cyc = -1;
        int busy_fall = -1, gap_hi = 0, unstable = 0, ones = 0;
        logic [W-1:0] mosi_word = '0;
        logic clk_a  [0:T_FREE];
        logic mosi_a [0:T_FREE];
        loop_mode  = lb;
        miso_drv   = 1'b0;
        start      = 1'b1;
        value_mosi = tx;
        clk_a[0]   = pin_clk;
        mosi_a[0]  = pin_mosi;
        for (int c = 1; c <= T_FREE; c++) begin
            @(negedge system_clk);
            if (c == 1) begin
                start      = hold;
                value_mosi = hold ? next_tx : W'($urandom);
                check_eq("ncs_fall_cycle1", pin_ncs, 1'b0);
                check_eq("busy_cycle1", busy, 1'b1);
            end
            if (c == reject_at) begin
                start      = 1'b1;
                value_mosi = 8'hFF;
            end
            if (reject_at > 0 && c == reject_at + 1) start = 1'b0;
            clk_a[c]  = pin_clk;
            mosi_a[c] = pin_mosi;
            if (pin_mosi === 1'b1) ones++;
            if (pin_clk === 1'b1 && clk_a[c-1] === 1'b0) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                mosi_word = {mosi_word[W-2:0], pin_mosi};
            end
            if (c == 1) miso_drv = rx[W-1];
            else if (pin_clk === 1'b0 && clk_a[c-1] === 1'b1 && rises < W) miso_drv = rx[W-1-rises];
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                check_eq("value_miso", value_miso, lb ? tx : rx);
            end
            if (pin_ncs === 1'b1) gap_hi++;
            if (busy !== 1'b1 && busy_fall < 0) busy_fall = c;
        end
        check_eq("rising_edges", rises, W);
        check_eq("first_rise_cycle", first_rise, H + 1);
        check_eq("mosi_bits", mosi_word, tx);
        check_eq("done_count", done_cnt, 1);
        check_eq("done_cycle", done_cyc, T_DONE);
        check_eq("busy_fall_cycle", busy_fall, T_FREE);
        check_eq("ncs_high_gap", gap_hi, H + 1);
        for (int r = 1; r <= T_FREE; r++) begin
            if (clk_a[r] === 1'b1 && clk_a[r-1] === 1'b0) begin
                for (int k = r - H; k < r + H; k++) begin
                    if (mosi_a[k] !== mosi_a[r]) unstable++;
                end
            end
        end
        check_eq("mosi_stable", unstable, 0);
        if (reject_at > 0) check_eq("mosi_all_zero", ones, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        value_mosi = '0;
        loop_mode  = 1'b0;
        miso_drv   = 1'b0;
        repeat (3) @(negedge system_clk);
        check_eq("rst_ncs", pin_ncs, 1'b1);
        check_eq("rst_clk", pin_clk, 1'b0);
        check_eq("rst_mosi", pin_mosi, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_value_miso", value_miso, '0);
        reset = 1'b0;
        @(negedge system_clk);

        // Loopback with the reference pattern
        run_xfer(8'hA5, 8'h00, 1'b1, 0, 1'b0, 8'h00);
        idle_cycles(4, "idle_after_a5");

        // start while busy must be ignored
        run_xfer(8'h00, 8'h5A, 1'b0, 10, 1'b0, 8'h00);
        idle_cycles(12, "no_second_xfer");

        // start held high: second transfer accepted the cycle busy drops
        run_xfer(8'h3C, 8'h96, 1'b0, 0, 1'b1, 8'hC3);
        run_xfer(8'hC3, 8'h69, 1'b0, 0, 1'b0, 8'h00);
        idle_cycles(2, "idle_after_b2b");

        // Random words, random loopback / driven MISO
        for (int n = 0; n < 6; n++) begin
            run_xfer(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0, 8'h00);
            idle_cycles(2, "idle_after_rand");
        end

        // Make sure value_miso is non-zero before the abort
        run_xfer(8'hE7, 8'hB4, 1'b0, 0, 1'b0, 8'h00);

        // Abort mid-transfer; start coincident with reset is ignored
        loop_mode  = 1'b1;
        start      = 1'b1;
        value_mosi = 8'hF0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge system_clk);
            if (c == 1) start = 1'b0;
        end
        check_eq("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge system_clk);
        check_eq("abort_ncs", pin_ncs, 1'b1);
        check_eq("abort_clk", pin_clk, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_value_miso", value_miso, '0);
        reset = 1'b0;
        start = 1'b0;
        idle_cycles(6, "abort_quiet");
        run_xfer(8'h81, 8'h42, 1'b0, 0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
